div_sign_restore: RTL

Post-stage of the multicycle signed divider. Captures the operand sign and zero flags when a divide starts, waits for the unsigned magnitude quotient/remainder from the divider core, and restores two's-complement signs over two cycles using one shared negator. Raises an exception for divide-by-zero and for quotient overflow. Holds the signed result under a valid/ready handshake until the register-file writeback accepts it.

---
 rtl/div_sign_restore_pkg.sv | 20 ++
 rtl/div_sign_restore_if.sv | 37 +++
 rtl/div_sign_restore_negate32.sv | 26 ++
 rtl/div_sign_restore.sv | 117 +++++++++++
 4 files changed

// File: rtl/div_sign_restore_pkg.sv
// Shared divider package: datapath width, controller state encoding and the
// signed-result payload carried out of the sign-restore stage.
package div_sign_restore_pkg;

  localparam int unsigned WIDTH = 32;

  // State encoding shared with the divider core's controller.
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_MAG = 3'd1;
  localparam logic [2:0] NEG_Q    = 3'd2;
  localparam logic [2:0] NEG_R    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             exception;
  } result_t;

endpackage

// File: rtl/div_sign_restore_if.sv
// Handshake/bus bundle between the divider front end, divider core,
// sign-restore stage and register-file writeback.
//   start/a_sign/b_sign/b_zero          : divide launch and operand flags
//   mag_valid/mag_quotient/mag_remainder: unsigned magnitudes from the core
//   result_valid/result_ready           : writeback handshake
//   quotient/remainder/exception/busy   : signed result and status
interface div_sign_restore_if #(
  parameter int unsigned W = div_sign_restore_pkg::WIDTH
);
  logic         start;
  logic         a_sign;
  logic         b_sign;
  logic         b_zero;
  logic         mag_valid;
  logic [W-1:0] mag_quotient;
  logic [W-1:0] mag_remainder;
  logic         result_ready;
  logic         result_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         exception;
  logic         busy;

  modport master (
    output start, a_sign, b_sign, b_zero,
    output mag_valid, mag_quotient, mag_remainder,
    output result_ready,
    input  result_valid, quotient, remainder, exception, busy
  );

  modport slave (
    input  start, a_sign, b_sign, b_zero,
    input  mag_valid, mag_quotient, mag_remainder,
    input  result_ready,
    output result_valid, quotient, remainder, exception, busy
  );
endinterface

// File: rtl/div_sign_restore_negate32.sv
// Two's-complement negator: bitwise NOT followed by a carry-in-1 add of zero.
//   a : operand
//   y : ~a + 1 (modulo 2^W); 0 -> 0, 0x80000000 -> 0x80000000
module div_sign_restore_negate32 #(
  parameter int unsigned W = div_sign_restore_pkg::WIDTH
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  logic [W-1:0] a_n;
  logic [W:0]   carry;

  // With a zero second operand every generate term is 0, so the lookahead
  // carry into bit i is carry-in ANDed with all lower propagate bits.
  always_comb begin
    a_n      = ~a;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      carry[i+1] = a_n[i] & carry[i];
    end
    y = a_n ^ carry[W-1:0];
  end

endmodule

// File: rtl/div_sign_restore.sv
// Sign-restore post-stage of the multicycle signed divider.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state and outputs
//   bus   : slave side of div_sign_restore_if (launch flags, magnitudes in,
//           registered signed result/exception/busy out under valid/ready)
module div_sign_restore
  import div_sign_restore_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  div_sign_restore_if.slave       bus
);

  logic [2:0]       state_q, state_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] mag_q_q, mag_q_d;
  logic [WIDTH-1:0] mag_r_q, mag_r_d;
  result_t          res_q, res_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] neg_in;
  logic [WIDTH-1:0] neg_out;
  logic             handshake;
  logic             take_start;

  // One negator shared by both sign-fix cycles.
  assign neg_in = (state_q == NEG_R) ? mag_r_q : mag_q_q;

  div_sign_restore_negate32 #(.W(WIDTH)) u_negate (
    .a (neg_in),
    .y (neg_out)
  );

  // State and registered-output storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      mag_q_q <= '0;
      mag_r_q <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      mag_q_q <= mag_q_d;
      mag_r_q <= mag_r_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    mag_q_d    = mag_q_q;
    mag_r_d    = mag_r_q;
    res_d      = res_q;
    handshake  = valid_q & bus.result_ready;
    take_start = bus.start &
                 ((state_q == IDLE) | ((state_q == DONE) & handshake));

    case (state_q)
      IDLE: ;
      WAIT_MAG: begin
        if (bus.mag_valid) begin
          mag_q_d = bus.mag_quotient;
          mag_r_d = bus.mag_remainder;
          state_d = NEG_Q;
        end
      end
      NEG_Q: begin
        res_d.quotient  = q_neg_q ? neg_out : mag_q_q;
        // Positive quotient with the top bit set only arises from INT_MIN / -1.
        res_d.exception = ~q_neg_q & mag_q_q[WIDTH-1];
        state_d         = NEG_R;
      end
      NEG_R: begin
        res_d.remainder = r_neg_q ? neg_out : mag_r_q;
        state_d         = DONE;
      end
      DONE: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start accepted in IDLE, or on the DONE handshake edge, overrides the above.
    if (take_start) begin
      q_neg_d = bus.a_sign ^ bus.b_sign;
      r_neg_d = bus.a_sign;
      if (bus.b_zero) begin
        state_d = DONE;
        res_d   = '{quotient: '0, remainder: '0, exception: 1'b1};
      end else begin
        state_d = WAIT_MAG;
      end
    end

    valid_d = (state_d == DONE);
    busy_d  = (state_d == WAIT_MAG) | (state_d == NEG_Q) | (state_d == NEG_R);
  end

  assign bus.result_valid = valid_q;
  assign bus.quotient     = res_q.quotient;
  assign bus.remainder    = res_q.remainder;
  assign bus.exception    = res_q.exception;
  assign bus.busy         = busy_q;

endmodule
